// File: rtl/alu_control_sequencer_if.sv
// Handshake and result bus between the main control unit (master) and the
// ALU control sequencer (slave).
interface alu_control_sequencer_if #(
    parameter int N_FUNCT = 6,
    parameter int M_OP    = 2,
    parameter int L_CTRL  = 4,
    parameter int ILL_W   = 8
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [N_FUNCT-1:0] funct;
    logic [M_OP-1:0]    ALU_Op;
    logic [L_CTRL-1:0]  ALU_Control;
    logic               res_valid;
    logic               stall;
    logic               illegal;
    logic [ILL_W-1:0]   illegal_cnt;

    modport master (
        output flush, in_valid, funct, ALU_Op,
        input  in_ready, ALU_Control, res_valid, stall, illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, funct, ALU_Op,
        output in_ready, ALU_Control, res_valid, stall, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Registered ALU control decoder that sequences multi-cycle multiply/divide,
// stalls the pipeline while busy, and flags/counts undecodable funct codes.
module alu_control_sequencer #(
    parameter int N_FUNCT = 6,
    parameter int M_OP    = 2,
    parameter int L_CTRL  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int ILL_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_control_sequencer_if.slave   bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [L_CTRL-1:0] CTRL_NONE = L_CTRL'(4'b0000);
    localparam logic [L_CTRL-1:0] CTRL_ADDI = L_CTRL'(4'b0001);
    localparam logic [L_CTRL-1:0] CTRL_SUBI = L_CTRL'(4'b0010);
    localparam logic [L_CTRL-1:0] CTRL_ADD  = L_CTRL'(4'b0011);
    localparam logic [L_CTRL-1:0] CTRL_SUB  = L_CTRL'(4'b0100);
    localparam logic [L_CTRL-1:0] CTRL_MUL  = L_CTRL'(4'b0101);
    localparam logic [L_CTRL-1:0] CTRL_DIV  = L_CTRL'(4'b0110);
    localparam logic [L_CTRL-1:0] CTRL_OR   = L_CTRL'(4'b0111);
    localparam logic [L_CTRL-1:0] CTRL_AND  = L_CTRL'(4'b1000);
    localparam logic [L_CTRL-1:0] CTRL_XOR  = L_CTRL'(4'b1001);
    localparam logic [L_CTRL-1:0] CTRL_SLL  = L_CTRL'(4'b1010);
    localparam logic [L_CTRL-1:0] CTRL_SRL  = L_CTRL'(4'b1011);
    localparam logic [L_CTRL-1:0] CTRL_SLT  = L_CTRL'(4'b1100);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MULTI = 2'b01,
        DONE  = 2'b10
    } state_t;

    // R-type decode of the funct field; unknown codes map to CTRL_NONE.
    function automatic logic [L_CTRL-1:0] decode_funct(input logic [N_FUNCT-1:0] fn);
        logic [L_CTRL-1:0] c;
        c = CTRL_NONE;
        case (fn)
            N_FUNCT'(0): c = CTRL_ADD;
            N_FUNCT'(1): c = CTRL_SUB;
            N_FUNCT'(2): c = CTRL_MUL;
            N_FUNCT'(3): c = CTRL_DIV;
            N_FUNCT'(4): c = CTRL_OR;
            N_FUNCT'(5): c = CTRL_AND;
            N_FUNCT'(6): c = CTRL_XOR;
            N_FUNCT'(7): c = CTRL_SLL;
            N_FUNCT'(8): c = CTRL_SRL;
            N_FUNCT'(9): c = CTRL_SLT;
            default:     c = CTRL_NONE;
        endcase
        return c;
    endfunction

    // funct values above 9 have no ALU meaning under the R-type class.
    function automatic logic funct_is_illegal(input logic [N_FUNCT-1:0] fn);
        return (fn > N_FUNCT'(9));
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [L_CTRL-1:0]  ctrl_r;
    logic               res_valid_r;
    logic               illegal_r;
    logic [ILL_W-1:0]   ill_cnt_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [L_CTRL-1:0]  dec_ctrl_s;
    logic               dec_ill_s;
    logic               dec_multi_s;
    logic [CNT_W-1:0]   dec_cnt_s;
    logic               ill_sat_s;

    // Handshake: ready drops while a multi-cycle op runs and during reset.
    always_comb begin
        in_ready_s = ~reset & (state_r != MULTI);
        accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
        ill_sat_s  = (ill_cnt_r == {ILL_W{1'b1}});
    end

    // Decode of the presented op, consumed only on accept.
    always_comb begin
        dec_ctrl_s  = CTRL_NONE;
        dec_ill_s   = 1'b0;
        dec_multi_s = 1'b0;
        dec_cnt_s   = CNT_W'(0);
        case (bus.ALU_Op)
            M_OP'(0): dec_ctrl_s = CTRL_ADDI;
            M_OP'(1): dec_ctrl_s = CTRL_SUBI;
            M_OP'(2): dec_ctrl_s = CTRL_SLT;
            M_OP'(3): begin
                dec_ctrl_s = decode_funct(bus.funct);
                dec_ill_s  = funct_is_illegal(bus.funct);
            end
            default: begin
                dec_ctrl_s = CTRL_NONE;
                dec_ill_s  = 1'b1;
            end
        endcase
        if (dec_ctrl_s == CTRL_MUL) begin
            dec_multi_s = 1'b1;
            dec_cnt_s   = CNT_W'(MUL_LAT - 1);
        end else if (dec_ctrl_s == CTRL_DIV) begin
            dec_multi_s = 1'b1;
            dec_cnt_s   = CNT_W'(DIV_LAT - 1);
        end else begin
            dec_multi_s = 1'b0;
            dec_cnt_s   = CNT_W'(0);
        end
    end

    // Sequencer FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            ctrl_r      <= CTRL_NONE;
            res_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            ill_cnt_r   <= ILL_W'(0);
        end else if (bus.flush) begin
            // Abort drops any in-flight op but keeps the last decode visible.
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                MULTI: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= DONE;
                        res_valid_r <= 1'b1;
                    end else begin
                        state_r     <= MULTI;
                        res_valid_r <= 1'b0;
                    end
                end
                IDLE, DONE: begin
                    if (accept_s) begin
                        ctrl_r    <= dec_ctrl_s;
                        illegal_r <= dec_ill_s;
                        if (dec_ill_s && !ill_sat_s) begin
                            ill_cnt_r <= ill_cnt_r + ILL_W'(1);
                        end else begin
                            ill_cnt_r <= ill_cnt_r;
                        end
                        if (dec_multi_s) begin
                            state_r     <= MULTI;
                            cnt_r       <= dec_cnt_s;
                            res_valid_r <= 1'b0;
                        end else begin
                            state_r     <= DONE;
                            cnt_r       <= CNT_W'(0);
                            res_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_W'(0);
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.stall       = bus.in_valid & ~in_ready_s;
    assign bus.ALU_Control = ctrl_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.illegal     = illegal_r;
    assign bus.illegal_cnt = ill_cnt_r;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomised and directed check of alu_control_sequencer against a
// cycle-level behavioural model.
module tb_alu_control_sequencer;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic reset;

    alu_control_sequencer_if #(.N_FUNCT(6), .M_OP(2), .L_CTRL(4), .ILL_W(8)) bus ();

    alu_control_sequencer #(
        .N_FUNCT(6), .M_OP(2), .L_CTRL(4),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ILL_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: busy = edges still to wait before the result appears.
    logic [3:0] m_ctrl = 4'd0;
    bit         m_ill  = 1'b0;
    int         m_cnt  = 0;
    bit         m_rv   = 1'b0;
    int         m_busy = 0;
    bit         m_live = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] c;
        bit         ill;
        int         lat;
        if (reset) begin
            m_ctrl = 4'd0; m_ill = 1'b0; m_cnt = 0; m_rv = 1'b0; m_busy = 0; m_live = 1'b1;
        end else if (bus.flush) begin
            m_rv = 1'b0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            m_rv   = (m_busy == 0);
        end else if (bus.in_valid) begin
            ill = 1'b0;
            lat = 1;
            case (bus.ALU_Op)
                2'd0: c = 4'd1;
                2'd1: c = 4'd2;
                2'd2: c = 4'd12;
                default: begin
                    if (bus.funct <= 6'd9) c = 4'(int'(bus.funct) + 3);
                    else begin c = 4'd0; ill = 1'b1; end
                    if (bus.funct == 6'd2) lat = MUL_LAT;
                    if (bus.funct == 6'd3) lat = DIV_LAT;
                end
            endcase
            m_ctrl = c;
            m_ill  = ill;
            if (ill && m_cnt < 255) m_cnt = m_cnt + 1;
            m_busy = lat - 1;
            m_rv   = (lat == 1);
        end else begin
            m_rv = 1'b0;
        end
    endtask

    task automatic compare();
        bit rdy;
        if (m_live) begin
            rdy = !reset && (m_busy == 0);
            chk("in_ready",    32'(bus.in_ready),    32'(rdy));
            chk("stall",       32'(bus.stall),       32'(bus.in_valid && !rdy));
            chk("ALU_Control", 32'(bus.ALU_Control), 32'(m_ctrl));
            chk("res_valid",   32'(bus.res_valid),   32'(m_rv));
            chk("illegal",     32'(bus.illegal),     32'(m_ill));
            chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_cnt));
        end
    endtask

    // One clock: drive inputs, check outputs, take the edge, advance model.
    task automatic cyc(input logic rs, input logic fl, input logic v,
                       input logic [1:0] op, input logic [5:0] fn);
        reset        = rs;
        bus.flush    = fl;
        bus.in_valid = v;
        bus.ALU_Op   = op;
        bus.funct    = fn;
        #1;
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] ctrl, input logic rv,
                           input logic ill, input logic [7:0] cnt);
        chk({nm, "_ctrl"}, 32'(bus.ALU_Control), 32'(ctrl));
        chk({nm, "_rv"},   32'(bus.res_valid),   32'(rv));
        chk({nm, "_ill"},  32'(bus.illegal),     32'(ill));
        chk({nm, "_cnt"},  32'(bus.illegal_cnt), 32'(cnt));
    endtask

    initial begin
        reset = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b1; bus.ALU_Op = 2'd3; bus.funct = 6'd2;

        // Reset with a valid op pending: nothing is accepted.
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 6'd2);
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 6'd2);
        chk_out("rst", 4'd0, 1'b0, 1'b0, 8'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_stall",    32'(bus.stall),    32'd1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops.
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 6'd0);
        chk_out("b2b0", 4'b0001, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd5);
        chk_out("b2b1", 4'b1000, 1'b1, 1'b0, 8'd0);
        chk("b2b_stall", 32'(bus.stall), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        chk("b2b_idle_rv", 32'(bus.res_valid), 32'd0);

        // Multiply with inputs held through the busy window.
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd2);
        for (int k = 1; k <= 3; k++) begin
            chk("mul_busy_ready", 32'(bus.in_ready),  32'd0);
            chk("mul_busy_stall", 32'(bus.stall),     32'd1);
            chk("mul_busy_rv",    32'(bus.res_valid), 32'd0);
            cyc(1'b0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 2'd3, 6'd2);
        end
        chk_out("mul_done", 4'b0101, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        chk("mul_no_reaccept", 32'(bus.res_valid), 32'd0);

        // slt class ignores funct entirely.
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 6'd0);
        chk_out("slt0", 4'b1100, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 6'd9);
        chk_out("slt9", 4'b1100, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 6'd63);
        chk_out("slt63", 4'b1100, 1'b1, 1'b0, 8'd0);

        // Illegal funct and counter saturation.
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'h3F);
        chk_out("ill1", 4'b0000, 1'b1, 1'b1, 8'd1);
        for (int k = 1; k < 300; k++) cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'h3F);
        chk_out("ill300", 4'b0000, 1'b1, 1'b1, 8'd255);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd0);
        chk_out("ill_sat_hold", 4'b0011, 1'b1, 1'b0, 8'd255);

        // Divide aborted by flush in its third busy cycle.
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 6'd3);
        chk_out("div_flush", 4'b0110, 1'b0, 1'b0, 8'd255);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
            chk("div_flush_rv", 32'(bus.res_valid), 32'd0);
        end
        chk("div_flush_ready", 32'(bus.in_ready), 32'd1);

        // Same abort via reset.
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 6'd3);
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 6'd3);
        chk_out("div_rst", 4'd0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
            chk("div_rst_rv", 32'(bus.res_valid), 32'd0);
        end

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 3000; k++) begin
            logic       rs, fl, v;
            logic [1:0] op;
            logic [5:0] fn;
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 9));
            cyc(rs, fl, v, op, fn);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
